// File: rtl/phy_pkg.sv
// Shared PHY definitions: line symbols and the transmit lane state encoding.
package phy_pkg;

    localparam logic [7:0] COMMA_K28_5          = 8'hBC;
    localparam int         DEFAULT_TRAIN_COMMAS = 4;

    typedef enum logic {
        TRAIN = 1'b0,
        RUN   = 1'b1
    } tx_state_t;

endpackage

// File: rtl/paralelo_serie_tx.sv
// One-lane parallel-to-serial transmitter: sends training commas after reset,
// then shifts out accepted bytes MSB first, one bit per clk_8f cycle.
module paralelo_serie_tx
    import phy_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter logic [DATA_W-1:0] COMMA        = COMMA_K28_5,
    parameter int                TRAIN_COMMAS = DEFAULT_TRAIN_COMMAS
) (
    input  logic              clk_8f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              frame_start,
    output logic              active_out
);

    localparam int             CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [3:0]     CCNT_END = 4'(TRAIN_COMMAS);

    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [DATA_W-1:0] sr, sr_next;
    logic [3:0]        ccnt, ccnt_next;
    tx_state_t         state, state_next;

    // cnt resets to the last bit position so the very first edge is a load edge.
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            cnt   <= CNT_LAST;
            sr    <= '0;
            ccnt  <= '0;
            state <= TRAIN;
        end else begin
            cnt   <= cnt_next;
            sr    <= sr_next;
            ccnt  <= ccnt_next;
            state <= state_next;
        end
    end

    always_comb begin
        cnt_next   = cnt + 1'b1;
        sr_next    = {sr[DATA_W-2:0], 1'b0};
        ccnt_next  = ccnt;
        state_next = state;
        if (cnt == CNT_LAST) begin
            cnt_next = '0;
            if (state == TRAIN) begin
                // Switch to RUN on the edge that loads the final training comma.
                sr_next   = COMMA;
                ccnt_next = ccnt + 1'b1;
                if (ccnt_next == CCNT_END) begin
                    state_next = RUN;
                end
            end else if (valid_in) begin
                sr_next = data_in;
            end else begin
                sr_next = COMMA;
            end
        end
    end

    // cnt only reaches 0 after a real edge, so frame_start stays low in reset.
    assign data_out    = sr[DATA_W-1];
    assign frame_start = (cnt == '0);
    assign ready_out   = (state == RUN) && (cnt == CNT_LAST);
    assign active_out  = (state == RUN);

endmodule

// File: tb/tb_paralelo_serie_tx.sv
// Directed bench for paralelo_serie_tx: training, data words, ignored strobes
// outside ready_out, and a reset in the middle of a word.
module tb_paralelo_serie_tx;

    logic       clk_8f;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       frame_start;
    logic       active_out;

    int checks = 0;
    int errors = 0;

    logic [8:0] stim_tab [16];
    logic [7:0] exp_words [$];

    paralelo_serie_tx dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .frame_start (frame_start),
        .active_out  (active_out)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    task automatic check_bit(input string tag, input int n, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d: observed %b expected %b", tag, n, obs, exp);
        end
    endtask

    // Word k (0-based) occupies cycles 8k+1..8k+8; words 0..3 are training commas.
    task automatic build_expected();
        exp_words.delete();
        for (int k = 0; k < 16; k++) begin
            if (k < 4 || !stim_tab[k][8]) exp_words.push_back(8'hBC);
            else                          exp_words.push_back(stim_tab[k][7:0]);
        end
    endtask

    task automatic check_output(input int n);
        logic [7:0] w;
        int         b;
        w = exp_words[(n - 1) / 8];
        b = 7 - ((n - 1) % 8);
        check_bit("data_out",    n, data_out,    w[b]);
        check_bit("frame_start", n, frame_start, ((n - 1) % 8) == 0);
        check_bit("ready_out",   n, ready_out,   (n >= 32) && (n % 8 == 0));
        check_bit("active_out",  n, active_out,  n >= 25);
    endtask

    // Outside ready cycles the upstream keeps offering 8'h55, which must be ignored.
    task automatic apply_stimulus(input int n);
        int k;
        if (n >= 32 && n % 8 == 0) begin
            k = n / 8;
            {valid_in, data_in} = (k < 16) ? stim_tab[k] : 9'h000;
        end else begin
            valid_in = 1'b1;
            data_in  = 8'h55;
        end
    endtask

    task automatic run_phase(input int cycles);
        build_expected();
        for (int n = 1; n <= cycles; n++) begin
            @(negedge clk_8f);
            check_output(n);
            apply_stimulus(n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_bit({tag, "_data_out"},    0, data_out,    1'b0);
        check_bit({tag, "_frame_start"}, 0, frame_start, 1'b0);
        check_bit({tag, "_ready_out"},   0, ready_out,   1'b0);
        check_bit({tag, "_active_out"},  0, active_out,  1'b0);
    endtask

    initial begin
        reset    = 1'b0;
        valid_in = 1'b1;
        data_in  = 8'h55;
        repeat (2) @(negedge clk_8f);
        check_reset_outputs("por");
        reset = 1'b1;

        // A5, comma, 00 FF 3C back-to-back, two idle commas, then F0 to be cut by reset.
        foreach (stim_tab[i]) stim_tab[i] = 9'h000;
        stim_tab[4]  = {1'b1, 8'hA5};
        stim_tab[6]  = {1'b1, 8'h00};
        stim_tab[7]  = {1'b1, 8'hFF};
        stim_tab[8]  = {1'b1, 8'h3C};
        stim_tab[11] = {1'b1, 8'hF0};
        run_phase(92);

        reset    = 1'b0;
        valid_in = 1'b0;
        #1;
        check_reset_outputs("midword");
        repeat (2) @(negedge clk_8f);
        check_reset_outputs("held");
        reset = 1'b1;

        foreach (stim_tab[i]) stim_tab[i] = 9'h000;
        stim_tab[4] = {1'b1, 8'hC3};
        run_phase(48);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
